// File: rtl/size_patch_writer.sv
// size_patch_writer: queues byte-size patch requests and writes each one big-endian, one byte per cycle, into the output buffer.
// Optional feature: define SIZE_PATCH_COUNT_EN to add the patch_count output.
module size_patch_writer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] offset_addr,
  input  logic [31:0] val,
  input  logic [31:0] byte_size,
  input  logic        mem_busy,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        idle,
  output logic        overflow,
  output logic        size_error
`ifdef SIZE_PATCH_COUNT_EN
  ,
  output logic [31:0] patch_count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q;
  logic [31:0] fifo_addr_q [FIFO_DEPTH];
  logic [31:0] fifo_val_q [FIFO_DEPTH];
  logic [2:0] fifo_size_q [FIFO_DEPTH];
  logic [31:0] addr_q, val_q;
  logic [2:0] n_q, k_q;
  logic [1:0] sh;
  logic req_ok, req_bad, full, pop, push, last;
  logic overflow_q, size_error_q;
  logic mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_data_q, mem_data_d;
  assign req_ok = (byte_size != 32'd0) && (byte_size <= 32'd4);
  assign req_bad = byte_size > 32'd4;
  assign full = count_q == (AW+1)'(FIFO_DEPTH);
  assign pop = (state_q == IDLE) && (count_q != '0);
  // a full queue still accepts when the head leaves in the same cycle
  assign push = req_ok && (!full || pop);
  assign last = k_q == n_q - 3'd1;
  // byte index within val, most significant significant byte first
  assign sh = 2'(n_q - k_q - 3'd1);
  assign idle = (state_q == IDLE) && (count_q == '0);
  assign overflow = overflow_q;
  assign size_error = size_error_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  // queue storage: data only, validity comes from the pointers
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= offset_addr;
      fifo_val_q[wr_ptr_q] <= val;
      fifo_size_q[wr_ptr_q] <= byte_size[2:0];
    end
  end
  // queue pointers, occupancy and sticky error flags
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
      size_error_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      overflow_q <= overflow_q | (req_ok && full && !pop);
      size_error_q <= size_error_q | req_bad;
    end
  end
  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  // FSM next state
  always_comb begin
    state_d = (state_q == IDLE) ? (pop ? WRITE : IDLE) : ((!mem_busy && last) ? IDLE : WRITE);
  end
  // FSM outputs: the byte to strobe this edge, zeroed when not writing
  always_comb begin
    mem_we_d = (state_q == WRITE) && !mem_busy;
    mem_addr_d = mem_we_d ? addr_q + {29'd0, k_q} : 32'd0;
    mem_data_d = mem_we_d ? val_q[{sh, 3'b000} +: 8] : 8'd0;
  end
  // working registers for the entry being written
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      val_q <= '0;
      n_q <= '0;
      k_q <= '0;
    end else if (pop) begin
      addr_q <= fifo_addr_q[rd_ptr_q];
      val_q <= fifo_val_q[rd_ptr_q];
      n_q <= fifo_size_q[rd_ptr_q];
      k_q <= '0;
    end else if (mem_we_d) begin
      k_q <= k_q + 3'd1;
    end
  end
  // registered memory write port
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end
`ifdef SIZE_PATCH_COUNT_EN
  logic last_q;
  logic [31:0] patch_count_q;
  assign patch_count = patch_count_q;
  // count completed patches one cycle after their final strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= 1'b0;
      patch_count_q <= '0;
    end else begin
      last_q <= mem_we_d && last;
      patch_count_q <= patch_count_q + {31'd0, last_q};
    end
  end
`endif
endmodule

// File: tb/tb_size_patch_writer.sv
// tb_size_patch_writer: table vectors, corner sequences and a random scoreboard run for size_patch_writer.
module tb_size_patch_writer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [31:0] offset_addr = '0, val = '0, byte_size = '0;
  logic mem_busy = 1'b0;
  logic mem_we, idle, overflow, size_error;
  logic [31:0] mem_addr;
  logic [7:0] mem_data;
`ifdef SIZE_PATCH_COUNT_EN
  logic [31:0] patch_count;
`endif
  size_patch_writer #(.FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .offset_addr(offset_addr), .val(val), .byte_size(byte_size),
    .mem_busy(mem_busy), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .idle(idle), .overflow(overflow), .size_error(size_error)
`ifdef SIZE_PATCH_COUNT_EN
    , .patch_count(patch_count)
`endif
  );
  always #5 clock = ~clock;
  typedef struct {
    logic [31:0] a, v, s, exp_bytes;
  } vec_t;
  typedef struct {
    logic [31:0] a;
    logic [7:0] d;
    bit last;
  } exp_t;
  vec_t vecs[4];
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, outst = 0;
  bit bad_seen = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic push_req(input logic [31:0] a, input logic [31:0] v, input logic [31:0] s);
    @(negedge clock);
    offset_addr = a;
    val = v;
    byte_size = s;
    @(negedge clock);
    byte_size = 0;
  endtask
  task automatic enqueue(input logic [31:0] a, input logic [31:0] v, input int s);
    exp_t e;
    for (int j = 0; j < s; j++) begin
      e.a = a + 32'(j);
      e.d = 8'(v >> (8 * (s - 1 - j)));
      e.last = (j == s - 1);
      q.push_back(e);
    end
  endtask
  task automatic observe();
    exp_t e;
    if (mem_we) begin
      if (q.size() == 0) chk("spurious_we", 32'(mem_we), 0);
      else begin
        e = q.pop_front();
        chk("sb_addr", mem_addr, e.a);
        chk("sb_data", 32'(mem_data), 32'(e.d));
        if (e.last) outst--;
      end
    end else begin
      chk("zero_addr", mem_addr, 0);
      chk("zero_data", 32'(mem_data), 0);
    end
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    q.delete();
    outst = 0;
    bad_seen = 0;
  endtask
  initial begin
    vecs[0] = '{32'h10, 32'h0000ABCD, 32'd2, 32'hABCD0000};
    vecs[1] = '{32'h0, 32'h12345678, 32'd4, 32'h12345678};
    vecs[2] = '{32'h1000, 32'hFFFFFF5A, 32'd1, 32'h5A000000};
    vecs[3] = '{32'hFFFFFFFE, 32'h00C0FFEE, 32'd3, 32'hC0FFEE00};
    repeat (2) @(negedge clock);
    reset = 0;
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", 32'(mem_data), 0);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_serr", 32'(size_error), 0);
    for (int i = 0; i < 4; i++) begin
      push_req(vecs[i].a, vecs[i].v, vecs[i].s);
      chk("lat_0", 32'(mem_we), 0);
      @(negedge clock);
      chk("lat_1", 32'(mem_we), 0);
      for (int j = 0; j < int'(vecs[i].s); j++) begin
        @(negedge clock);
        chk("tbl_we", 32'(mem_we), 1);
        chk("tbl_addr", mem_addr, vecs[i].a + 32'(j));
        chk("tbl_data", 32'(mem_data), 32'(8'(vecs[i].exp_bytes >> (24 - 8 * j))));
      end
      @(negedge clock);
      chk("tbl_end_we", 32'(mem_we), 0);
      chk("tbl_end_idle", 32'(idle), 1);
    end
`ifdef SIZE_PATCH_COUNT_EN
    chk("patch_count", patch_count, 4);
`endif
    push_req(32'h20, 32'hDEADBEEF, 4);
    @(negedge clock);
    @(negedge clock);
    chk("stall_b0", 32'(mem_data), 32'hDE);
    @(negedge clock);
    chk("stall_b1", 32'(mem_data), 32'hAD);
    mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stall_we", 32'(mem_we), 0);
    end
    mem_busy = 0;
    @(negedge clock);
    chk("stall_b2_we", 32'(mem_we), 1);
    chk("stall_b2_addr", mem_addr, 32'h22);
    chk("stall_b2", 32'(mem_data), 32'hBE);
    @(negedge clock);
    chk("stall_b3_addr", mem_addr, 32'h23);
    chk("stall_b3", 32'(mem_data), 32'hEF);
    push_req(32'h40, 32'h11223344, 5);
    chk("serr_set", 32'(size_error), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("serr_no_we", 32'(mem_we), 0);
    end
    chk("serr_idle", 32'(idle), 1);
    push_req(32'h50, 32'hCAFEF00D, 4);
    repeat (3) @(negedge clock);
    chk("rmid_b1", 32'(mem_data), 32'hFE);
    reset = 1;
    offset_addr = 32'h60;
    byte_size = 2;
    @(negedge clock);
    reset = 0;
    byte_size = 0;
    for (int i = 0; i < 8; i++) begin
      chk("rmid_no_we", 32'(mem_we), 0);
      @(negedge clock);
    end
    chk("rmid_ovf", 32'(overflow), 0);
    chk("rmid_serr", 32'(size_error), 0);
    chk("rmid_idle", 32'(idle), 1);
`ifdef SIZE_PATCH_COUNT_EN
    chk("patch_count_rst", patch_count, 0);
`endif
    mem_busy = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      offset_addr = 32'h100 * 32'(i + 1);
      val = $urandom;
      byte_size = 32'(i % 4 + 1);
      if (i < 5) begin
        enqueue(offset_addr, val, i % 4 + 1);
        outst++;
      end
    end
    @(negedge clock);
    byte_size = 0;
    chk("ovf_set", 32'(overflow), 1);
    mem_busy = 0;
    for (int i = 0; i < 100 && q.size() > 0; i++) begin
      @(negedge clock);
      observe();
    end
    chk("ovf_drained", 32'(q.size()), 0);
    @(negedge clock);
    observe();
    chk("ovf_idle", 32'(idle), 1);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      observe();
      chk("rnd_ovf", 32'(overflow), 0);
      mem_busy = ($urandom_range(0, 3) == 0);
      if (outst < 4 && $urandom_range(0, 2) == 0) begin
        int s;
        s = $urandom_range(1, 4);
        offset_addr = $urandom;
        val = $urandom;
        byte_size = 32'(s);
        enqueue(offset_addr, val, s);
        outst++;
      end else if ($urandom_range(0, 49) == 0) begin
        byte_size = 32'($urandom_range(5, 1000));
        bad_seen = 1;
      end else byte_size = 0;
    end
    @(negedge clock);
    byte_size = 0;
    mem_busy = 0;
    observe();
    for (int i = 0; i < 100 && q.size() > 0; i++) begin
      @(negedge clock);
      observe();
    end
    chk("rnd_drained", 32'(q.size()), 0);
    @(negedge clock);
    observe();
    chk("rnd_idle", 32'(idle), 1);
    chk("rnd_serr", 32'(size_error), 32'(bad_seen));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/size_patch_writer.md
SIZE_PATCH_WRITER -- requirements
Module: size_patch_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: patch-request queue depth in entries (power of two, at least 2).
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 offset_addr  input  32  byte offset of the patch within the output buffer.
REQ-005 val  input  32  value to patch; low byte_size bytes are significant.
REQ-006 byte_size  input  32  patch width in bytes; a nonzero value marks a valid request in that cycle.
REQ-007 mem_busy  input  1  output-buffer port owned by the stream writer; no write is issued while high.
REQ-008 mem_we  output  1  byte write strobe.
REQ-009 mem_addr  output  32  byte address of the write.
REQ-010 mem_data  output  8  byte written.
REQ-011 idle  output  1  high when the queue is empty and the FSM is in IDLE.
REQ-012 overflow  output  1  sticky: a request was dropped because the queue was full.
REQ-013 size_error  output  1  sticky: a request had a byte_size greater than 4.

Function
REQ-014 A cycle with byte_size in 1..4 pushes {offset_addr, val, byte_size[2:0]} into the FIFO at that rising edge.
REQ-015 A request with byte_size greater than 4 is not queued and sets size_error at that edge.
REQ-016 Push when full with no pop in the same cycle: request dropped, overflow set, queue unchanged.
REQ-017 Push when full with a pop in the same cycle: request accepted, overflow not set.
REQ-018 FSM states: IDLE and WRITE.
REQ-019 IDLE with FIFO non-empty: pop the head entry into working registers (addr, val, remaining = byte_size, k = 0), then go to WRITE.
REQ-020 IDLE with FIFO empty: stay in IDLE.
REQ-021 WRITE with mem_busy low: mem_we=1, mem_addr = addr + k, mem_data = val[8*(n-1-k)+7 : 8*(n-1-k)] (big-endian, n = entry byte_size); then k increments.
REQ-022 WRITE with mem_busy high: mem_we=0 and k held.
REQ-023 After the byte with k = n-1 is written, return to IDLE.
REQ-024 mem_we, mem_addr and mem_data are registered outputs.
REQ-025 Latency: for a push at edge t into an empty queue with mem_busy low, the first mem_we is high in the cycle after edge t+2.
REQ-026 An n-byte patch produces exactly n consecutive strobes while mem_busy stays low.
REQ-027 Back-to-back entries are separated by exactly one IDLE cycle with mem_we=0.
REQ-028 mem_addr arithmetic is modulo 2^32; wrap-around is permitted and not flagged.
REQ-029 mem_addr and mem_data are 0 in any cycle where mem_we=0.
REQ-030 The FIFO pointers wrap modulo FIFO_DEPTH; occupancy counts 0..FIFO_DEPTH, distinguishing full from empty.
REQ-031 idle is combinational from FSM state and occupancy.

Reset
REQ-032 reset high at an edge forces: FSM to IDLE, FIFO empty, mem_we=0, mem_addr=0, mem_data=0, overflow=0, size_error=0.
REQ-033 reset mid-patch abandons the patch and all queued entries; no further strobe follows, and bytes already written stay written.
REQ-034 A request presented in the same cycle as reset is discarded.

Configuration
REQ-035 Macro SIZE_PATCH_COUNT_EN, when defined, adds output patch_count (32 bits): reset to 0, increments by 1 in the cycle after each entry's last byte is written, wraps modulo 2^32.
REQ-036 Without SIZE_PATCH_COUNT_EN, the patch_count port and its counter are absent; all other behaviour is identical.

Verification
REQ-037 Single patch: offset_addr=0x10, val=0x0000ABCD, byte_size=2, mem_busy=0 -> strobes (0x10,0xAB),(0x11,0xCD); first strobe in the cycle after edge t+2; idle high afterwards.
REQ-038 Four-byte patch: offset_addr=0, val=0x12345678, byte_size=4 -> strobes (0,0x12),(1,0x34),(2,0x56),(3,0x78) on four consecutive cycles.
REQ-039 Stall: byte_size=4 patch with mem_busy high for 3 cycles after the second byte -> no strobe for 3 cycles, then bytes 2 and 3 complete with the same addresses and data.
REQ-040 Overflow: 6 consecutive pushes with FIFO_DEPTH=4 while mem_busy is held high -> overflow=1, only the entries accepted into the queue (the first popped entry plus 4 queued) are written, each as a complete patch, in push order.
REQ-041 Error and reset: byte_size=5 -> size_error=1 and no strobe; reset asserted mid-way through a 4-byte write -> no further strobe, overflow=0, size_error=0, idle=1.
REQ-042 With SIZE_PATCH_COUNT_EN defined: 3 patches -> patch_count=3; a reset then returns patch_count to 0.
